// File: rtl/mem_sys_pkg.sv
// mem_sys_pkg: shared widths, address-field split and controller states for the memory system.
package mem_sys_pkg;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 16;
    localparam int NUM_LINES  = 16;
    localparam int MEM_LAT    = 4;
    localparam int WSEL_W     = $clog2(LINE_WORDS);
    localparam int OFF_W      = WSEL_W + 2;
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = ADDR_W - OFF_W - IDX_W;
    localparam int WADDR_W    = ADDR_W - 2;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE_MEM, RESP} state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [WSEL_W-1:0] wsel;
    } addr_f_t;

    // Fields of a word address (byte address with addr[1:0] dropped).
    function automatic addr_f_t split_addr(input logic [WADDR_W-1:0] i_wa);
        return addr_f_t'(i_wa);
    endfunction
endpackage

// File: rtl/main_memory.sv
// main_memory: word-addressed backing store, one access at a time, ack pulse MEM_LAT cycles after req.
module main_memory
    import mem_sys_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [WADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0]  i_wdata,
    output logic               o_ack,
    output logic [DATA_W-1:0]  o_rdata
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    // Words are stored XORed with their own byte address, so a zeroed array reads back word i as i*4.
    logic [DATA_W-1:0] r_mem [2**WADDR_W];
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [WADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_pat;
    logic              w_accept;

    assign w_pat    = DATA_W'({r_addr, 2'b00});
    assign o_ack    = r_busy && r_cnt == CNT_W'(1);
    assign o_rdata  = r_mem[r_addr] ^ w_pat;
    assign w_accept = i_req && (!r_busy || o_ack);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(MEM_LAT);
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end else if (o_ack) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (o_ack && r_we) r_mem[r_addr] <= r_wdata ^ w_pat;
    end
endmodule

// File: rtl/memory_system_top.sv
// memory_system_top: direct-mapped write-through, no-write-allocate cache in front of main_memory.
module memory_system_top
    import mem_sys_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ready,
    output logic              o_cpu_hit,
    output logic [DATA_W-1:0] o_cpu_rdata
);
    state_t             r_state, w_next;
    logic [WADDR_W-1:0] r_wa;
    logic               r_we;
    logic [DATA_W-1:0]  r_wdata;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [NUM_LINES];
    logic [DATA_W-1:0]  r_data [NUM_LINES*LINE_WORDS];
    logic [WSEL_W-1:0]  r_word;
    logic               r_wait;
    logic               r_ready;
    logic               r_hit;
    logic [DATA_W-1:0]  r_rdata;
    addr_f_t            w_f;
    logic               w_hit, w_last;
    logic               w_mem_req, w_mem_ack;
    logic [WADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0]  w_mem_rdata;
    logic               w_dwe;
    logic [IDX_W+WSEL_W-1:0] w_dsel;
    logic [DATA_W-1:0]  w_dwdata;
    logic               w_unused;

    assign w_unused    = ^i_cpu_addr[1:0];
    assign w_f         = split_addr(r_wa);
    assign w_hit       = r_valid[w_f.idx] && r_tag[w_f.idx] == w_f.tag;
    assign w_last      = r_word == WSEL_W'(LINE_WORDS - 1);
    assign o_cpu_ready = r_ready;
    assign o_cpu_hit   = r_hit;
    assign o_cpu_rdata = r_rdata;

    // Next refill word is requested in the ack cycle so words stream back-to-back.
    assign w_mem_req  = (r_state == REFILL && (!r_wait || (w_mem_ack && !w_last))) ||
                        (r_state == WRITE_MEM && !r_wait);
    assign w_mem_addr = r_state == WRITE_MEM ? r_wa :
                        {w_f.tag, w_f.idx, r_wait ? r_word + WSEL_W'(1) : r_word};
    assign w_dwe      = (r_state == LOOKUP && r_we && w_hit) || (r_state == REFILL && w_mem_ack);
    assign w_dsel     = {w_f.idx, r_state == REFILL ? r_word : w_f.wsel};
    assign w_dwdata   = r_state == REFILL ? w_mem_rdata : r_wdata;

    main_memory u_mem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (w_mem_req),
        .i_we    (r_state == WRITE_MEM),
        .i_addr  (w_mem_addr),
        .i_wdata (r_wdata),
        .o_ack   (w_mem_ack),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = i_cpu_req ? LOOKUP : IDLE;
            LOOKUP:    w_next = r_we ? WRITE_MEM : (w_hit ? RESP : REFILL);
            REFILL:    w_next = w_mem_ack && w_last ? RESP : REFILL;
            WRITE_MEM: w_next = w_mem_ack ? RESP : WRITE_MEM;
            RESP:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_wa    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_valid <= '0;
            r_word  <= '0;
            r_wait  <= 1'b0;
            r_ready <= 1'b0;
            r_hit   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= r_state == RESP;
            r_wait  <= w_mem_req || (r_wait && !w_mem_ack);
            if (r_state == IDLE && i_cpu_req) begin
                r_wa    <= i_cpu_addr[ADDR_W-1:2];
                r_we    <= i_cpu_we;
                r_wdata <= i_cpu_wdata;
            end
            if (r_state == LOOKUP) begin
                r_hit  <= w_hit;
                r_word <= '0;
                if (!r_we && w_hit) r_rdata <= r_data[{w_f.idx, w_f.wsel}];
                if (!r_we && !w_hit) r_valid[w_f.idx] <= 1'b0;
            end
            if (r_state == REFILL && w_mem_ack) begin
                r_word <= r_word + WSEL_W'(1);
                if (r_word == w_f.wsel) r_rdata <= w_mem_rdata;
                if (w_last) r_valid[w_f.idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == REFILL && w_mem_ack && w_last) r_tag[w_f.idx] <= w_f.tag;
    end

    always_ff @(posedge i_clk) begin
        if (w_dwe) r_data[w_dsel] <= w_dwdata;
    end
endmodule

// File: tb/tb_memory_system_top.sv
// tb_memory_system_top: randomized requests checked every cycle against a line-level cache/memory model.
module tb_memory_system_top;
    import mem_sys_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              ready, hit;
    logic [DATA_W-1:0] rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = -10;
    bit chk_en = 1'b0;
    logic              e_hit = 1'b0;
    logic [DATA_W-1:0] e_rdata = '0;

    logic [DATA_W-1:0] mmem [int];
    bit mv [NUM_LINES];
    int mt [NUM_LINES];

    memory_system_top dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cpu_req   (req),
        .i_cpu_we    (we),
        .i_cpu_addr  (addr),
        .i_cpu_wdata (wdata),
        .o_cpu_ready (ready),
        .o_cpu_hit   (hit),
        .o_cpu_rdata (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mread(input int w);
        return mmem.exists(w) ? mmem[w] : DATA_W'(w * 4);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Ready must pulse exactly on the model's completion cycle; results hold from then on.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("ready", 32'(ready), 32'(cyc == done_cyc));
            if (cyc >= done_cyc) begin
                check("hit", 32'(hit), 32'(e_hit));
                check("rdata", rdata, e_rdata);
            end
        end
    end

    task automatic do_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int wa;
        int idx;
        int tg;
        bit h;
        int lat;
        wa  = int'(a[ADDR_W-1:2]);
        idx = int'(a[9:6]);
        tg  = int'(a[ADDR_W-1:10]);
        @(negedge clk);
        h = mv[idx] && mt[idx] == tg;
        if (w) begin
            mmem[wa] = d;
            lat = 3 + MEM_LAT;
        end else begin
            e_rdata = mread(wa);
            lat = h ? 2 : 3 + LINE_WORDS * MEM_LAT;
            if (!h) begin
                mv[idx] = 1'b1;
                mt[idx] = tg;
            end
        end
        e_hit = h;
        done_cyc = cyc + 1 + lat;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        while (cyc < done_cyc) begin
            req   = ($urandom_range(0, 3) == 0);
            we    = 1'($urandom);
            addr  = ADDR_W'($urandom);
            wdata = $urandom;
            @(negedge clk);
        end
        req = 1'b0;
    endtask

    task automatic lit(input string n, input logic h, input logic [DATA_W-1:0] d);
        check({n, "_ready"}, 32'(ready), 32'd1);
        check({n, "_hit"}, 32'(hit), 32'(h));
        check({n, "_rdata"}, rdata, d);
        check({n, "_model_hit"}, 32'(e_hit), 32'(h));
        check({n, "_model_rdata"}, e_rdata, d);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        repeat (hold) begin
            req  = 1'b1;
            addr = ADDR_W'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1;
        req = 1'b0;
        foreach (mv[i]) mv[i] = 1'b0;
        e_hit = 1'b0;
        e_rdata = '0;
        done_cyc = cyc;
        chk_en = 1'b1;
    endtask

    task automatic abort_read(input logic [ADDR_W-1:0] a, input int n);
        @(negedge clk);
        chk_en = 1'b0;
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        repeat (n) @(negedge clk);
        do_reset(2);
    endtask

    initial begin
        do_reset(3);
        do_req(1'b0, 16'h0008, '0);         lit("rd8_miss", 1'b0, 32'h0000_0008);
        do_req(1'b0, 16'h0008, '0);         lit("rd8_hit", 1'b1, 32'h0000_0008);
        do_req(1'b1, 16'h0008, 32'hAABBCCDD); lit("wr8_hit", 1'b1, 32'h0000_0008);
        do_req(1'b0, 16'h0008, '0);         lit("rd8_new", 1'b1, 32'hAABBCCDD);
        do_req(1'b0, 16'h0040, '0);         lit("rd40_miss", 1'b0, 32'h0000_0040);
        do_req(1'b0, 16'h0044, '0);         lit("rd44_hit", 1'b1, 32'h0000_0044);
        do_req(1'b0, 16'h0408, '0);         lit("rd408_conflict", 1'b0, 32'h0000_0408);
        do_req(1'b0, 16'h0008, '0);         lit("rd8_evicted", 1'b0, 32'hAABBCCDD);
        do_req(1'b1, 16'h1000, 32'h12345678); lit("wr1000_miss", 1'b0, 32'hAABBCCDD);
        do_req(1'b0, 16'h1000, '0);         lit("rd1000_miss", 1'b0, 32'h12345678);
        abort_read(16'h0C48, 20);
        do_req(1'b0, 16'h0C48, '0);         lit("rdC48_after_abort", 1'b0, 32'h0000_0C48);
        do_req(1'b0, 16'h0C4C, '0);         lit("rdC4C_hit", 1'b1, 32'h0000_0C4C);
        for (int i = 0; i < 150; i++) begin
            do_req($urandom_range(0, 9) < 3,
                   {6'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)},
                   $urandom);
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
